spi_frame_responder: RTL and testbench

- SPI-slave-side frame decoder: the receiving end of the sensor-frame and command-register transfers issued by the SPI master controller.
- Sits behind a byte-oriented SPI slave core and consumes its received bytes.
- Decodes write frames: opcode, address, then WORDS 32-bit little-endian words, emitted as indexed word writes.
- Answers read frames: returns a 32-bit command word MSB-first through the slave core's transmit preload handshake.

---
 rtl/spi_frame_responder.sv | 193 +++++++++++++++++++
 tb/tb_spi_frame_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_responder.sv
// SPI slave-side frame decoder. Consumes bytes from a byte-oriented slave core.
// Write frames become indexed 32-bit word writes.
// Read frames return a command word, captured at frame start, MSB-first.
module spi_frame_responder #(
    parameter int          WORDS    = 8,
    parameter logic [7:0]  OP_WRITE = 8'h02,
    parameter logic [7:0]  OP_READ  = 8'h00,
    localparam int         IW       = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cs_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_byte,
    input  logic          tx_req,
    output logic [7:0]    tx_byte,
    output logic          tx_wren,
    input  logic [31:0]   cmd_word,
    output logic          word_valid,
    output logic [IW-1:0] word_index,
    output logic [31:0]   word_data,
    output logic          frame_done,
    output logic          read_done,
    output logic          frame_error,
    output logic          busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_OPCODE = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;

    localparam logic [7:0] PAYLOAD  = 8'(4 * WORDS);
    localparam logic [7:0] FULL_CNT = 8'(4 * WORDS + 2);

    logic [2:0]    state, state_nx;
    logic          cs_n_prev;
    // Set once cs_n has been seen high, so a reset released mid-frame does
    // not mistake the still-low chip select for a fresh falling edge.
    logic          armed;
    logic [7:0]    rx_cnt, rx_cnt_nx;
    logic [7:0]    tx_cnt;
    logic          err, err_nx;
    logic          wr_mode, wr_nx;
    logic          rd_mode, rd_nx;
    logic [31:0]   shadow;
    logic [IW-1:0] base;
    logic [31:0]   asm_word;
    logic [7:0]    b;
    logic          rx_acc, word_hit, data_byte;
    logic          frame_start, frame_end;
    logic [7:0]    tx_sel;

    assign busy        = (state != S_IDLE);
    assign frame_start = armed && cs_n_prev && !cs_n;
    // A byte arriving in the same cycle as the rising cs_n is still accepted
    // because state has not yet returned to IDLE.
    assign frame_end   = !cs_n_prev && cs_n && (state != S_IDLE);
    assign rx_acc      = rx_valid && (state != S_IDLE);
    assign b           = rx_cnt - 8'd2;
    assign data_byte   = rx_acc && (state == S_WDATA) && (b != PAYLOAD);

    // Next-state decode of the received byte; end evaluation uses these values.
    always_comb begin
        state_nx  = state;
        err_nx    = err;
        wr_nx     = wr_mode;
        rd_nx     = rd_mode;
        word_hit  = 1'b0;
        rx_cnt_nx = rx_cnt;
        if (rx_acc && rx_cnt != 8'hFF)
            rx_cnt_nx = rx_cnt + 8'd1;
        if (rx_acc) begin
            case (state)
                S_OPCODE: begin
                    if (rx_byte == OP_WRITE) begin
                        state_nx = S_ADDR;
                        wr_nx    = 1'b1;
                    end else if (rx_byte == OP_READ) begin
                        state_nx = S_ADDR;
                        rd_nx    = 1'b1;
                    end else begin
                        state_nx = S_DRAIN;
                        err_nx   = 1'b1;
                    end
                end
                S_ADDR:  state_nx = wr_mode ? S_WDATA : S_RDATA;
                S_WDATA: begin
                    if (b == PAYLOAD) begin
                        state_nx = S_DRAIN;
                        err_nx   = 1'b1;
                    end else if (b[1:0] == 2'd3) begin
                        word_hit = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Transmit byte for the requested transfer: command word bytes 2..5 on reads.
    always_comb begin
        tx_sel = 8'h00;
        if (!cs_n && !frame_start && rd_mode) begin
            case (tx_cnt)
                8'd2:    tx_sel = shadow[31:24];
                8'd3:    tx_sel = shadow[23:16];
                8'd4:    tx_sel = shadow[15:8];
                8'd5:    tx_sel = shadow[7:0];
                default: tx_sel = 8'h00;
            endcase
        end
    end

    // Frame tracking, word assembly, end-of-frame pulses and tx preload.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cs_n_prev   <= 1'b1;
            armed       <= 1'b0;
            rx_cnt      <= '0;
            tx_cnt      <= '0;
            err         <= 1'b0;
            wr_mode     <= 1'b0;
            rd_mode     <= 1'b0;
            shadow      <= '0;
            base        <= '0;
            asm_word    <= '0;
            tx_byte     <= '0;
            tx_wren     <= 1'b0;
            word_valid  <= 1'b0;
            word_index  <= '0;
            word_data   <= '0;
            frame_done  <= 1'b0;
            read_done   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            cs_n_prev   <= cs_n;
            if (cs_n)
                armed <= 1'b1;
            tx_wren     <= 1'b0;
            word_valid  <= 1'b0;
            frame_done  <= 1'b0;
            read_done   <= 1'b0;
            frame_error <= 1'b0;

            if (tx_req) begin
                tx_wren <= 1'b1;
                tx_byte <= tx_sel;
                if (tx_cnt != 8'hFF)
                    tx_cnt <= tx_cnt + 8'd1;
            end

            if (frame_start) begin
                state   <= S_OPCODE;
                rx_cnt  <= '0;
                tx_cnt  <= '0;
                err     <= 1'b0;
                wr_mode <= 1'b0;
                rd_mode <= 1'b0;
                shadow  <= cmd_word;
            end else begin
                rx_cnt  <= rx_cnt_nx;
                err     <= err_nx;
                wr_mode <= wr_nx;
                rd_mode <= rd_nx;
                state   <= frame_end ? S_IDLE : state_nx;

                if (rx_acc && state == S_ADDR)
                    base <= rx_byte[IW-1:0];
                if (data_byte)
                    asm_word[{b[1:0], 3'b000} +: 8] <= rx_byte;
                if (word_hit) begin
                    word_valid <= 1'b1;
                    word_data  <= {rx_byte, asm_word[23:0]};
                    word_index <= base + b[IW+1:2];
                end

                if (frame_end && rx_cnt_nx != 8'd0) begin
                    if (wr_nx && !err_nx && rx_cnt_nx == FULL_CNT)
                        frame_done <= 1'b1;
                    else if (rd_nx && !err_nx && rx_cnt_nx >= 8'd6)
                        read_done <= 1'b1;
                    else
                        frame_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_responder.sv
// Scoreboard bench for spi_frame_responder: expected words, tx bytes and
// end-of-frame pulses are queued as stimulus is driven and checked on output.
module tb_spi_frame_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_req = 1'b0;
    logic [31:0] cmd_word = 32'h0;
    logic [7:0]  tx_byte;
    logic        tx_wren;
    logic        word_valid;
    logic [2:0]  word_index;
    logic [31:0] word_data;
    logic        frame_done, read_done, frame_error, busy;

    spi_frame_responder #(.WORDS(8)) dut (
        .clock(clock), .reset_n(reset_n), .cs_n(cs_n),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_req(tx_req),
        .tx_byte(tx_byte), .tx_wren(tx_wren), .cmd_word(cmd_word),
        .word_valid(word_valid), .word_index(word_index), .word_data(word_data),
        .frame_done(frame_done), .read_done(read_done),
        .frame_error(frame_error), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    logic [34:0] word_q[$];
    logic [7:0]  tx_q[$];
    logic [2:0]  end_q[$];
    logic        req_d = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) req_d <= tx_req;

    // Output monitor: pop and compare every strobe the DUT produces.
    always @(negedge clock) begin
        if (word_valid) begin
            if (word_q.size() == 0) chk("word_unexpected", 1, 0);
            else chk("word", {word_index, word_data}, word_q.pop_front());
        end
        if (tx_wren || req_d)
            chk("tx_wren_timing", tx_wren, req_d);
        if (tx_wren) begin
            if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
            else chk("tx_byte", tx_byte, tx_q.pop_front());
        end
        if (frame_done || read_done || frame_error) begin
            if (end_q.size() == 0) chk("end_unexpected", 1, 0);
            else chk("end_pulse", {frame_error, read_done, frame_done}, end_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] v);
        @(posedge clock); #1;
        rx_valid = 1'b1;
        rx_byte  = v;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic cs_fall();
        @(posedge clock); #1;
        cs_n = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic cs_rise();
        @(posedge clock); #1;
        cs_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    // Write frame with ndata payload bytes; pat 0 gives words 0..7, else random.
    task automatic write_frame(input logic [2:0] base, input int ndata, input int pat);
        logic [31:0] w[9];
        for (int k = 0; k < 9; k++) w[k] = (pat == 0) ? 32'(k) : $urandom;
        for (int k = 0; k < 8 && 4 * k + 3 < ndata; k++)
            word_q.push_back({3'(base + 3'(k)), w[k]});
        end_q.push_back(ndata == 32 ? 3'b001 : 3'b100);
        cs_fall();
        send_byte(8'h02);
        send_byte({5'b0, base});
        for (int i = 0; i < ndata; i++) send_byte(w[i / 4][8 * (i % 4) +: 8]);
        cs_rise();
    endtask

    logic [7:0] rd_in[6]  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] rd_exp[6] = '{8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w3[4];
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", {tx_byte, tx_wren, word_valid, word_index, word_data,
                              frame_done, read_done, frame_error, busy}, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Full write frames: base 0 with counting data, base 6 wrapping.
        write_frame(3'd0, 32, 0);
        write_frame(3'd6, 32, 1);

        // Read frame: shadow captured at cs_n fall, later cmd_word change ignored.
        cmd_word = 32'hDEADBEEF;
        cs_fall();
        cmd_word = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            tx_req = 1'b1;
            tx_q.push_back(rd_exp[i]);
            @(posedge clock); #1;
            tx_req = 1'b0;
            send_byte(rd_in[i]);
        end
        end_q.push_back(3'b010);
        cs_rise();
        // Request with chip select high is still answered, with zero.
        @(posedge clock); #1;
        tx_req = 1'b1;
        tx_q.push_back(8'h00);
        @(posedge clock); #1;
        tx_req = 1'b0;
        repeat (2) @(posedge clock);

        // Short and overlong write frames.
        write_frame(3'd2, 13, 1);
        write_frame(3'd0, 33, 1);

        // Empty frame: no pulse.
        cs_fall();
        cs_rise();

        // Bad opcode: drain, busy held, error on end.
        cs_fall();
        send_byte(8'h55);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        chk("busy_drain", busy, 1);
        end_q.push_back(3'b100);
        cs_rise();
        chk("busy_idle", busy, 0);

        // Reset during word 3, released with cs_n still low.
        for (int k = 0; k < 4; k++) w3[k] = $urandom;
        for (int k = 0; k < 3; k++) word_q.push_back({3'(k), w3[k]});
        cs_fall();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 13; i++) send_byte(w3[i / 4][8 * (i % 4) +: 8]);
        reset_n = 1'b0;
        #1;
        chk("midreset_outputs", {tx_byte, tx_wren, word_valid, word_index, word_data,
                                 frame_done, read_done, frame_error, busy}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'hA5);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_word", word_valid, 0);
        cs_rise();
        write_frame(3'd3, 32, 1);

        repeat (5) @(posedge clock);
        #1;
        chk("word_q_empty", word_q.size(), 0);
        chk("tx_q_empty", tx_q.size(), 0);
        chk("end_q_empty", end_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
